// File: rtl/fc_ctrl_pkg.sv
// Shared types and constants for the fully-connected layer MAC sequencer.
package fc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        WRITE,
        FIN
    } fc_state_t;

    localparam int unsigned MAC_PIPE_DEPTH = 3;
    localparam int unsigned DATA_W         = 14;

    // Address width for a memory of n words, never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_enable_pipe.sv
// Issue-valid shift register that walks each operand issue through the
// MAC multiplier, product register and accumulator enables.
module mac_enable_pipe
    import fc_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic issue,
    output logic enable_mult,
    output logic en_pipeline_reg,
    output logic en_acc
);

    logic [MAC_PIPE_DEPTH-1:0] valid_pipe;

    // Shift the issue bit one stage per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= {valid_pipe[MAC_PIPE_DEPTH-2:0], issue};
        end
    end

    assign enable_mult     = valid_pipe[0];
    assign en_pipeline_reg = valid_pipe[1];
    assign en_acc          = valid_pipe[2];

endmodule

// File: rtl/fc_layer_mac_ctrl.sv
// Sequencer for one saturating MAC computing y = W*x one neuron at a time.
// Build option: define FC_RELU_EN to clamp negative results to zero on write.
module fc_layer_mac_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned M_OUT = 4,
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned W_AW  = addr_w(M_OUT * N_IN),
    parameter int unsigned X_AW  = addr_w(N_IN),
    parameter int unsigned Y_AW  = addr_w(M_OUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [W_AW-1:0]  w_addr,
    output logic [X_AW-1:0]  x_addr,
    output logic             enable_mult,
    output logic             en_pipeline_reg,
    output logic             en_acc,
    output logic             clear_acc,
    input  logic [WIDTH-1:0] mac_f,
    output logic             y_wr_en,
    output logic [Y_AW-1:0]  y_addr,
    output logic [WIDTH-1:0] y_data
);

    localparam logic [X_AW-1:0] J_LAST    = X_AW'(N_IN - 1);
    localparam logic [Y_AW-1:0] I_LAST    = Y_AW'(M_OUT - 1);
    localparam logic [W_AW-1:0] ROW_STEP  = W_AW'(N_IN);
    localparam logic [1:0]      DRAIN_INI = 2'(MAC_PIPE_DEPTH - 1);

    fc_state_t       state;
    logic [Y_AW-1:0] i;
    logic [X_AW-1:0] j;
    logic [1:0]      drain_cnt;
    logic [W_AW-1:0] row_base;
    logic            issue;

    assign issue = (state == RUN);

    // Layer sequencing; every control output is set on the edge entering its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            drain_cnt <= '0;
            row_base  <= '0;
            w_addr    <= '0;
            x_addr    <= '0;
            clear_acc <= 1'b0;
            y_wr_en   <= 1'b0;
            y_addr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            clear_acc <= 1'b0;
            y_wr_en   <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        i         <= '0;
                        row_base  <= '0;
                        busy      <= 1'b1;
                        clear_acc <= 1'b1;
                    end
                end
                CLEAR: begin
                    state  <= RUN;
                    j      <= '0;
                    w_addr <= row_base;
                    x_addr <= '0;
                end
                RUN: begin
                    if (j == J_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_INI;
                    end else begin
                        j      <= j + X_AW'(1);
                        w_addr <= w_addr + W_AW'(1);
                        x_addr <= x_addr + X_AW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        state   <= WRITE;
                        y_wr_en <= 1'b1;
                        y_addr  <= i;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                WRITE: begin
                    if (i == I_LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state     <= CLEAR;
                        i         <= i + Y_AW'(1);
                        row_base  <= row_base + ROW_STEP;
                        clear_acc <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Issue-valid pipeline driving the MAC enables.
    mac_enable_pipe u_enable_pipe (
        .clk             (clk),
        .reset           (reset),
        .issue           (issue),
        .enable_mult     (enable_mult),
        .en_pipeline_reg (en_pipeline_reg),
        .en_acc          (en_acc)
    );

    // The final accumulator value is only valid in the write cycle, so it
    // passes straight through, gated by the registered write strobe.
`ifdef FC_RELU_EN
    assign y_data = (y_wr_en && !mac_f[WIDTH-1]) ? mac_f : '0;
`else
    assign y_data = y_wr_en ? mac_f : '0;
`endif

endmodule

// File: tb/tb_fc_layer_mac_ctrl.sv
// Bench for fc_layer_mac_ctrl: two controller instances each paired with a
// behavioural saturating MAC and memories; writes are scoreboarded.
module tb_fc_layer_mac_ctrl;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance A: N_IN=4, M_OUT=2 ----------------
    logic               start_a, busy_a, done_a;
    logic [2:0]         w_addr_a;
    logic [1:0]         x_addr_a;
    logic               em_a, ep_a, ea_a, ca_a, wr_a;
    logic [0:0]         y_addr_a;
    logic signed [13:0] mac_f_a, y_data_a;
    logic signed [13:0] wmem_a [8];
    logic signed [13:0] xmem_a [4];
    logic signed [13:0] wq_a, xq_a, mult_a, prod_a, acc_a;
    exp_t               q_a [$];
    int                 wr_cnt_a = 0;
    int                 done_cnt_a = 0;

    fc_layer_mac_ctrl #(.N_IN(4), .M_OUT(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .w_addr(w_addr_a), .x_addr(x_addr_a), .enable_mult(em_a),
        .en_pipeline_reg(ep_a), .en_acc(ea_a), .clear_acc(ca_a), .mac_f(mac_f_a),
        .y_wr_en(wr_a), .y_addr(y_addr_a), .y_data(y_data_a)
    );

    // ---------------- instance B: N_IN=1, M_OUT=1 ----------------
    logic               start_b, busy_b, done_b;
    logic [0:0]         w_addr_b, x_addr_b, y_addr_b;
    logic               em_b, ep_b, ea_b, ca_b, wr_b;
    logic signed [13:0] mac_f_b, y_data_b;
    logic signed [13:0] w_b, x_b;
    logic signed [13:0] wq_b, xq_b, mult_b, prod_b, acc_b;
    exp_t               q_b [$];

    fc_layer_mac_ctrl #(.N_IN(1), .M_OUT(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .w_addr(w_addr_b), .x_addr(x_addr_b), .enable_mult(em_b),
        .en_pipeline_reg(ep_b), .en_acc(ea_b), .clear_acc(ca_b), .mac_f(mac_f_b),
        .y_wr_en(wr_b), .y_addr(y_addr_b), .y_data(y_data_b)
    );

    function automatic logic signed [13:0] sat14(input int v);
        if (v > 8191)  return 14'sh1FFF;
        if (v < -8192) return 14'sh2000;
        return 14'(v);
    endfunction

    function automatic int relu(input int v);
`ifdef FC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Golden dot product for one row of instance A.
    function automatic int ref_a(input int row);
        int acc = 0;
        for (int c = 0; c < 4; c++) begin
            acc = int'(sat14(acc + int'(sat14(int'(wmem_a[row*4+c]) * int'(xmem_a[c])))));
        end
        return relu(acc);
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural MAC A: 1-cycle memory read, multiplier, product reg, accumulator.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wq_a <= '0; xq_a <= '0; mult_a <= '0; prod_a <= '0; acc_a <= '0;
        end else begin
            wq_a <= wmem_a[w_addr_a];
            xq_a <= xmem_a[x_addr_a];
            if (em_a) mult_a <= sat14(int'(wq_a) * int'(xq_a));
            if (ep_a) prod_a <= mult_a;
            if (ca_a)      acc_a <= '0;
            else if (ea_a) acc_a <= sat14(int'(acc_a) + int'(prod_a));
        end
    end
    assign mac_f_a = acc_a;

    // Behavioural MAC B (single-word memories).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wq_b <= '0; xq_b <= '0; mult_b <= '0; prod_b <= '0; acc_b <= '0;
        end else begin
            wq_b <= w_b;
            xq_b <= x_b;
            if (em_b) mult_b <= sat14(int'(wq_b) * int'(xq_b));
            if (ep_b) prod_b <= mult_b;
            if (ca_b)      acc_b <= '0;
            else if (ea_b) acc_b <= sat14(int'(acc_b) + int'(prod_b));
        end
    end
    assign mac_f_b = acc_b;

    // Scoreboard: compare every output-memory write against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (wr_a) begin
            wr_cnt_a++;
            if (q_a.size() == 0) begin
                check_eq("a_unexpected_write", 1, 0);
            end else begin
                e = q_a.pop_front();
                check_eq("a_y_addr", int'(y_addr_a), e.addr);
                check_eq("a_y_data", int'(y_data_a), e.data);
            end
        end
        if (done_a) done_cnt_a++;
        if (wr_b) begin
            if (q_b.size() == 0) begin
                check_eq("b_unexpected_write", 1, 0);
            end else begin
                e = q_b.pop_front();
                check_eq("b_y_addr", int'(y_addr_b), e.addr);
                check_eq("b_y_data", int'(y_data_b), e.data);
            end
        end
    end

    // Run one layer on A; optionally pulse start again at cycle 'extra'.
    task automatic run_layer_a(input string tag, input int extra);
        exp_t e;
        int   lat = -1;
        bit   busy_bad = 1'b0;
        int   row, col;
        for (int r = 0; r < 2; r++) begin
            e.addr = r;
            e.data = ref_a(r);
            q_a.push_back(e);
        end
        start_a = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_a = (k == extra);
            if (k == 1 || k == 10) check_eq({tag, "_clear_acc"}, int'(ca_a), 1);
            if (k == 2)            check_eq({tag, "_clear_low"}, int'(ca_a), 0);
            if (k == 2 || k == 5 || k == 6 || k == 11 || k == 14) begin
                row = (k > 9) ? 1 : 0;
                col = k - 2 - 9 * row;
                if (col > 3) col = 3;
                check_eq({tag, "_w_addr"}, int'(w_addr_a), row * 4 + col);
                check_eq({tag, "_x_addr"}, int'(x_addr_a), col);
            end
            if (done_a) begin
                lat = k;
                break;
            end
            if (!busy_a) busy_bad = 1'b1;
        end
        check_eq({tag, "_done_latency"}, lat, 19);
        check_eq({tag, "_busy_held"}, int'(busy_bad), 0);
        @(negedge clk);
        start_a = 1'b0;
        check_eq({tag, "_busy_after"}, int'(busy_a), 0);
    endtask

    // Single-issue layer on B with a per-cycle control-pin pattern check.
    task automatic run_b();
        exp_t       e;
        int         lat = -1;
        // {clear_acc, enable_mult, en_pipeline_reg, en_acc, y_wr_en, done}
        logic [5:0] pat [7] = '{6'b100000, 6'b000000, 6'b010000, 6'b001000,
                                6'b000100, 6'b000010, 6'b000001};
        e.addr = 0;
        e.data = relu(-12);
        q_b.push_back(e);
        start_b = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (k <= 7) check_eq("b_ctrl_pattern", int'({ca_b, em_b, ep_b, ea_b, wr_b, done_b}),
                                 int'(pat[k-1]));
            if (k == 2) check_eq("b_addr", int'({w_addr_b, x_addr_b}), 0);
            if (done_b) begin
                lat = k;
                break;
            end
        end
        check_eq("b_done_latency", lat, 7);
    endtask

    initial begin
        int done_snap, wr_snap;
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int done_snap, wr_snap;
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wmem_a[c]   = 14'(c + 1);
            wmem_a[c+4] = -14'sd1;
            xmem_a[c]   = 14'(c + 5);
        end
        w_b = 14'sd3;
        x_b = -14'sd4;
        repeat (2) @(negedge clk);
        check_eq("a_reset_outputs", int'({busy_a, done_a, w_addr_a, x_addr_a, em_a, ep_a, ea_a,
                                          ca_a, wr_a, y_addr_a, y_data_a}), 0);
        check_eq("b_reset_outputs", int'({busy_b, done_b, w_addr_b, x_addr_b, em_b, ep_b, ea_b,
                                          ca_b, wr_b, y_addr_b, y_data_b}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic layer, then a back-to-back layer started right after done.
        run_layer_a("basic", -1);
        run_layer_a("b2b", -1);
        repeat (2) @(negedge clk);

        // Start pulsed mid-layer must be ignored.
        run_layer_a("restart_ignored", 3);
        repeat (2) @(negedge clk);

        // Saturating row followed by a row that must begin from a cleared accumulator.
        for (int c = 0; c < 4; c++) begin
            wmem_a[c]   = 14'sh1FFF;
            wmem_a[c+4] = -14'sd1;
            xmem_a[c]   = 14'sd2;
        end
        repeat (2) @(negedge clk);
        run_layer_a("saturate", -1);
        repeat (2) @(negedge clk);

        // Minimal configuration.
        run_b();
        repeat (2) @(negedge clk);

        // Reset during RUN aborts the layer with no write and no done.
        done_snap = done_cnt_a;
        wr_snap   = wr_cnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_w_addr_pre", int'(w_addr_a), 1);
        reset = 1'b1;
        #1;
        check_eq("abort_outputs", int'({busy_a, done_a, w_addr_a, x_addr_a, em_a, ep_a, ea_a,
                                        ca_a, wr_a, y_addr_a, y_data_a}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("abort_no_done", done_cnt_a, done_snap);
        check_eq("abort_no_write", wr_cnt_a, wr_snap);
        run_layer_a("post_reset", -1);
        repeat (3) @(negedge clk);

        check_eq("a_queue_drained", q_a.size(), 0);
        check_eq("b_queue_drained", q_b.size(), 0);
        check_eq("a_write_count", wr_cnt_a, 10);
        check_eq("a_done_count", done_cnt_a, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_layer_mac_ctrl.md
Name: fc_layer_mac_ctrl

Overview:
- Sequencer for one saturating 14-bit MAC datapath computing a fully-connected layer y = W·x, one output neuron at a time.
- Issues weight/input memory read addresses and drives the MAC control pins: enable_mult, en_pipeline_reg, en_acc, clear_acc.
- Writes each finished accumulator value to the output memory.
- Sits between the layer-level top (start/done) and one MAC plus its weight, input and output memories.

Parameters:
- N_IN, 4, input vector length (dot-product length), ≥1
- M_OUT, 4, number of output neurons, ≥1
- WIDTH, 14, data width of MAC result and output memory word
- W_AW, $clog2(M_OUT*N_IN) (min 1), weight address width
- X_AW, $clog2(N_IN) (min 1), input address width
- Y_AW, $clog2(M_OUT) (min 1), output address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begins a layer when idle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last output written
- w_addr  out  W_AW  weight memory read address (1-cycle read latency)
- x_addr  out  X_AW  input memory read address (1-cycle read latency)
- enable_mult  out  1  MAC multiplier pipeline enable
- en_pipeline_reg  out  1  MAC product register enable
- en_acc  out  1  MAC accumulator enable
- clear_acc  out  1  MAC accumulator clear
- mac_f  in  WIDTH  signed MAC accumulator output
- y_wr_en  out  1  output memory write strobe
- y_addr  out  Y_AW  output memory write address
- y_data  out  WIDTH  output memory write data

Behaviour:
- Reset values: all outputs 0; state IDLE; row counter i=0; column counter j=0; valid pipe cleared. Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, CLEAR, RUN, DRAIN, WRITE, FIN.
- IDLE: start=1 -> CLEAR, i=0. start at any other time is ignored.
- CLEAR: one cycle, clear_acc=1, j=0 -> RUN.
- RUN: N_IN cycles, one issue per cycle.
  - w_addr = i*N_IN + j; x_addr = j; issue bit pushed into valid pipe.
  - On j==N_IN-1 -> DRAIN, otherwise j++.
- Valid pipe (3 stages v0..v2, shifts every cycle):
  - enable_mult = v0 (operands arrive one cycle after issue);
  - en_pipeline_reg = v1;
  - en_acc = v2.
  - Last issue at cycle c gives en_acc at c+3 and mac_f valid at c+4.
- DRAIN: exactly 3 cycles (down-counter) -> WRITE.
- WRITE: one cycle; y_wr_en=1, y_addr=i, y_data=f(mac_f).
  - If i==M_OUT-1 -> FIN; otherwise i++ and -> CLEAR.
- FIN: done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE. It drops in the same cycle done pulses low-to-IDLE, i.e. busy=0 from the cycle after FIN.
- Cycles per row: N_IN+5. done asserts M_OUT*(N_IN+5)+1 cycles after the start cycle.
- w_addr and x_addr hold their last value outside RUN.
- Control outputs are registered (glitch-free).
- The controller does no arithmetic on data: saturation belongs to the MAC.

Optional Feature:
- FC_RELU_EN defined: y_data = (mac_f negative) ? 0 : mac_f.
- FC_RELU_EN undefined: y_data = mac_f unchanged.
- Timing is identical in both builds.

Decomposition:
- Package fc_ctrl_pkg holds:
  - typedef enum logic[2:0] fc_state_t {IDLE, CLEAR, RUN, DRAIN, WRITE, FIN};
  - localparam MAC_PIPE_DEPTH = 3;
  - localparam DATA_W = 14.
- One sub-module, mac_enable_pipe: a MAC_PIPE_DEPTH-bit shift register with async reset, fanning out enable_mult, en_pipeline_reg and en_acc.

Test Plan:
- N_IN=4, M_OUT=2, W rows {1,2,3,4},{-1,-1,-1,-1}, x={5,6,7,8}, paired with the real MAC -> writes y[0]=70, y[1]=-26. done exactly 19 cycles after start; busy high throughout.
- Same stimulus with FC_RELU_EN -> y[0]=70, y[1]=0; write timing unchanged.
- Weights all 8191, x all 2, N_IN=4 -> y[0]=8191 (MAC saturation passes through untouched); clear_acc seen before row 1, y[1] starts from 0.
- N_IN=1, M_OUT=1, w=3, x=-4 -> y[0]=-12. done 7 cycles after start. Check enables: enable_mult, en_pipeline_reg, en_acc at issue+1/+2/+3.
- start pulsed again mid-layer -> ignored, addresses and write count unchanged. Then reset asserted during RUN -> all outputs 0 asynchronously, no y_wr_en, no done; a fresh start afterwards completes normally.
- Back-to-back layers: start in the cycle after done returns to IDLE -> accepted, second layer results identical.
